// File: rtl/pre_seq_tagger.sv
// AXI-Stream frame forwarder that can append a sequence-number trailer beat per frame.
// It also counts frames leaving the master side and exports the current sequence number.
module pre_seq_tagger #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEQ_W    = 16,
  parameter int unsigned SEQ_INIT = 1,
  parameter int unsigned CNT_W    = 64
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_areset,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  input  logic              ctrl_seq_en,
  input  logic              ctrl_rst_cntr_out,
  output logic [CNT_W-1:0]  slv_cntr_out,
  output logic [SEQ_W-1:0]  slv_seq_cur
);

  typedef enum logic {S_PASS, S_SEQ} state_t;

  state_t             state_q, state_d;
  logic [SEQ_W-1:0]   seq_ctr_q, seq_ctr_d;
  logic [CNT_W-1:0]   cntr_q, cntr_d;
  logic               in_frame_q, in_frame_d;
  logic               seq_en_f_q, seq_en_f_d;
  logic               en;
  logic               m_last_acc;

  // First beat of a frame decides with the live enable; later beats use the latched one.
  assign en = in_frame_q ? seq_en_f_q : ctrl_seq_en;

  always_comb begin
    state_d       = state_q;
    seq_ctr_d     = seq_ctr_q;
    in_frame_d    = in_frame_q;
    seq_en_f_d    = seq_en_f_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tlast  = 1'b0;
    if (!m_axis_areset) begin
      case (state_q)
        S_PASS: begin
          s_axis_tready = m_axis_tready;
          m_axis_tvalid = s_axis_tvalid;
          m_axis_tdata  = s_axis_tdata;
          m_axis_tlast  = s_axis_tlast && !en;
          if (s_axis_tvalid && m_axis_tready) begin
            if (!in_frame_q) begin
              seq_en_f_d = ctrl_seq_en;
            end
            in_frame_d = !s_axis_tlast;
            if (s_axis_tlast && en) begin
              state_d = S_SEQ;
            end
          end
        end
        S_SEQ: begin
          m_axis_tvalid = 1'b1;
          m_axis_tdata  = DATA_W'(seq_ctr_q);
          m_axis_tlast  = 1'b1;
          if (m_axis_tready) begin
            state_d = S_PASS;
            // Wrap skips zero and restarts at the configured first number.
            seq_ctr_d = (seq_ctr_q == {SEQ_W{1'b1}}) ? SEQ_W'(SEQ_INIT) : seq_ctr_q + SEQ_W'(1);
          end
        end
        default: state_d = S_PASS;
      endcase
    end
  end

  assign m_last_acc = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    cntr_d = cntr_q;
    if (ctrl_rst_cntr_out) begin
      cntr_d = '0;
    end else if (m_last_acc) begin
      cntr_d = cntr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q    <= S_PASS;
      seq_ctr_q  <= SEQ_W'(SEQ_INIT);
      cntr_q     <= '0;
      in_frame_q <= 1'b0;
      seq_en_f_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_ctr_q  <= seq_ctr_d;
      cntr_q     <= cntr_d;
      in_frame_q <= in_frame_d;
      seq_en_f_q <= seq_en_f_d;
    end
  end

  assign slv_cntr_out = cntr_q;
  assign slv_seq_cur  = seq_ctr_q;

endmodule

// File: tb/tb_pre_seq_tagger.sv
// Randomised bench for pre_seq_tagger with a frame-level reference model and directed pins.
// A narrow sequence counter and frame counter make the wrap behaviour reachable quickly.
module tb_pre_seq_tagger;

  localparam int DATA_W   = 32;
  localparam int SEQ_W    = 4;
  localparam int SEQ_INIT = 1;
  localparam int CNT_W    = 8;
  localparam int SEQ_MAX  = (1 << SEQ_W) - 1;
  localparam int CNT_MOD  = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              areset = 1'b1;
  logic              s_tvalid = 1'b0;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tready = 1'b0;
  logic              seq_en = 1'b0;
  logic              rst_cntr = 1'b0;
  logic [CNT_W-1:0]  cntr_out;
  logic [SEQ_W-1:0]  seq_cur;

  int checks = 0;
  int fails  = 0;
  int frames_out = 0;

  always #5 clk = ~clk;

  pre_seq_tagger #(
    .DATA_W(DATA_W), .SEQ_W(SEQ_W), .SEQ_INIT(SEQ_INIT), .CNT_W(CNT_W)
  ) dut (
    .m_axis_aclk      (clk),
    .m_axis_areset    (areset),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tdata     (s_tdata),
    .s_axis_tlast     (s_tlast),
    .s_axis_tready    (s_tready),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tdata     (m_tdata),
    .m_axis_tlast     (m_tlast),
    .m_axis_tready    (m_tready),
    .ctrl_seq_en      (seq_en),
    .ctrl_rst_cntr_out(rst_cntr),
    .slv_cntr_out     (cntr_out),
    .slv_seq_cur      (seq_cur)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of what must leave the master side.
  int model_seq      = SEQ_INIT;
  int model_cnt      = 0;
  bit trailer_owed   = 1'b0;
  bit mid_frame      = 1'b0;
  bit frame_tagged   = 1'b0;

  always begin
    bit e_valid, e_last, e_ready, tag;
    logic [DATA_W-1:0] e_data;
    @(negedge clk);
    #4;
    if (areset) begin
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_s_tready", s_tready, 0);
      model_seq    = SEQ_INIT;
      model_cnt    = 0;
      trailer_owed = 1'b0;
      mid_frame    = 1'b0;
      frame_tagged = 1'b0;
    end else begin
      tag = mid_frame ? frame_tagged : seq_en;
      if (trailer_owed) begin
        e_valid = 1'b1; e_data = DATA_W'(model_seq); e_last = 1'b1; e_ready = 1'b0;
      end else begin
        e_valid = s_tvalid; e_data = s_tdata; e_last = s_tlast && !tag; e_ready = m_tready;
      end
      chk("m_tvalid", m_tvalid, e_valid);
      chk("s_tready", s_tready, e_ready);
      if (e_valid) begin
        chk("m_tdata", m_tdata, e_data);
        chk("m_tlast", m_tlast, e_last);
      end
      chk("slv_cntr_out", cntr_out, model_cnt);
      chk("slv_seq_cur", seq_cur, model_seq);

      if (e_valid && m_tready && e_last) begin
        model_cnt = (model_cnt + 1) % CNT_MOD;
        frames_out++;
        $display("frame %0d out: last beat %h", frames_out, e_data);
      end
      if (rst_cntr) model_cnt = 0;

      if (trailer_owed) begin
        if (m_tready) begin
          trailer_owed = 1'b0;
          model_seq = (model_seq == SEQ_MAX) ? SEQ_INIT : model_seq + 1;
        end
      end else if (s_tvalid && m_tready) begin
        if (!mid_frame) frame_tagged = seq_en;
        if (s_tlast) begin
          mid_frame = 1'b0;
          if (tag) trailer_owed = 1'b1;
        end else begin
          mid_frame = 1'b1;
        end
      end
    end
  end

  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit l, input bit mr, input bit en);
    @(negedge clk);
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mr; seq_en = en;
    #4;
  endtask

  initial begin
    int len, idx, rst_left, stall_left, cr_left;
    bit have, acc;
    logic [DATA_W-1:0] cur;

    // Reset state with live inputs: nothing may pass.
    areset = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    repeat (2) begin
      @(negedge clk); #4;
      chk("pin_rst_tvalid", m_tvalid, 0);
    end
    @(negedge clk);
    areset = 1'b0; s_tvalid = 1'b0;
    #4;
    chk("pin_seq_init", seq_cur, 1);
    chk("pin_cnt_init", cntr_out, 0);

    // Two tagged 3-beat frames: trailers 1 and 2.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 3; i++) begin
        step(1, DATA_W'(32'hA0 + i), i == 2, 1, 1);
        chk("pin_beat_data", m_tdata, 32'hA0 + i);
        chk("pin_beat_last", m_tlast, 0);
      end
      step(0, '0, 0, 1, 1);
      chk("pin_trailer_data", m_tdata, f + 1);
      chk("pin_trailer_last", m_tlast, 1);
      chk("pin_trailer_sready", s_tready, 0);
    end
    step(0, '0, 0, 1, 0);
    chk("pin_cnt_2", cntr_out, 2);
    chk("pin_seq_3", seq_cur, 3);

    // Untagged 4-beat frame, enable raised mid-frame: no trailer.
    for (int i = 0; i < 4; i++) begin
      step(1, DATA_W'(32'hB0 + i), i == 3, 1, i != 0);
      chk("pin_untag_last", m_tlast, i == 3);
    end
    step(0, '0, 0, 1, 1);
    chk("pin_untag_no_trailer", m_tvalid, 0);
    chk("pin_untag_seq", seq_cur, 3);
    chk("pin_untag_cnt", cntr_out, 3);

    // One-beat tagged frame: two master beats.
    step(1, 32'hC0, 1, 1, 1);
    chk("pin_1beat_last", m_tlast, 0);
    step(0, '0, 0, 1, 1);
    chk("pin_1beat_trailer", m_tdata, 3);

    // Reset while a trailer is stalled.
    step(1, 32'h55, 1, 1, 1);
    step(0, '0, 0, 0, 1);
    chk("pin_stall_data", m_tdata, 4);
    step(0, '0, 0, 0, 1);
    chk("pin_stall_hold", m_tvalid, 1);
    @(negedge clk); areset = 1'b1; #4;
    chk("pin_abort_tvalid", m_tvalid, 0);
    @(negedge clk); areset = 1'b0; #4;
    chk("pin_abort_seq", seq_cur, 1);
    step(1, 32'h66, 1, 1, 1);
    step(0, '0, 0, 1, 1);
    chk("pin_post_abort_trailer", m_tdata, 1);

    // Random traffic checked by the model.
    have = 0; idx = 0; len = 0; acc = 0; cur = '0;
    rst_left = 0; stall_left = 0; cr_left = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (acc) begin
        s_tvalid = 1'b0;
        idx++;
        cur = $urandom;
        if (idx == len) have = 0;
      end
      if (!have) begin
        len = $urandom_range(1, 5); idx = 0; have = 1; cur = $urandom;
      end
      if (rst_left > 0) begin
        areset = 1'b1; rst_left--;
      end else begin
        areset = 1'b0;
        if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 2);
      end
      if (!s_tvalid) s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata = cur;
      s_tlast = (idx == len - 1);
      if (stall_left > 0) begin
        m_tready = 1'b0; stall_left--;
      end else begin
        m_tready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 49) == 0) stall_left = 5;
      end
      if ($urandom_range(0, 9) == 0) seq_en = ~seq_en;
      if (cr_left > 0) begin
        rst_cntr = 1'b1; cr_left--;
      end else begin
        rst_cntr = 1'b0;
        if ($urandom_range(0, 79) == 0) cr_left = 3;
      end
      #4;
      acc = s_tvalid && s_tready;
    end

    @(negedge clk); #5;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
